// File: rtl/serial_lsb_first_comparator.sv
// Serial magnitude comparator: operands arrive one bit pair per beat, LSB first.
// The most recent differing bit decides the result, so later (higher) bits dominate.
module serial_lsb_first_comparator #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic bit_ready,
  output logic busy,
  output logic result_valid,
  output logic less,
  output logic equal,
  output logic greater
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [CW-1:0] cnt;
  logic          run_eq;
  logic          run_lt;
  logic          run_gt;
  logic          accept;
  logic          last_beat;
  logic          nxt_eq;
  logic          nxt_lt;
  logic          nxt_gt;

  // A start request always wins over a beat presented in the same cycle.
  assign accept    = bit_valid && (state == SHIFT) && !start;
  assign last_beat = (cnt == LAST);

  assign bit_ready = (state == SHIFT);
  assign busy      = (state == SHIFT);

  always_comb begin
    nxt_eq = run_eq;
    nxt_lt = run_lt;
    nxt_gt = run_gt;
    if (a_bit != b_bit) begin
      nxt_eq = 1'b0;
      nxt_lt = ~a_bit & b_bit;
      nxt_gt = a_bit & ~b_bit;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = SHIFT;
      SHIFT: if (!start && accept && last_beat) next_state = DONE;
      DONE:  if (start) next_state = SHIFT;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      run_eq       <= 1'b0;
      run_lt       <= 1'b0;
      run_gt       <= 1'b0;
      result_valid <= 1'b0;
      less         <= 1'b0;
      equal        <= 1'b0;
      greater      <= 1'b0;
    end else if (start) begin
      cnt          <= '0;
      run_eq       <= 1'b1;
      run_lt       <= 1'b0;
      run_gt       <= 1'b0;
      result_valid <= 1'b0;
      less         <= 1'b0;
      equal        <= 1'b0;
      greater      <= 1'b0;
    end else if (accept) begin
      cnt    <= cnt + CW'(1);
      run_eq <= nxt_eq;
      run_lt <= nxt_lt;
      run_gt <= nxt_gt;
      // Final beat loads the result directly from the updated flags.
      if (last_beat) begin
        result_valid <= 1'b1;
        less         <= nxt_lt;
        equal        <= nxt_eq;
        greater      <= nxt_gt;
      end
    end
  end

endmodule

// File: tb/tb_serial_lsb_first_comparator.sv
// Directed bench for serial_lsb_first_comparator: an 8-bit instance and a 1-bit instance
// driven with hand-computed vectors.
module tb_serial_lsb_first_comparator;

  logic clk;
  logic rst_n;

  logic start, bit_valid, a_bit, b_bit;
  logic bit_ready, busy, result_valid, less, equal, greater;

  logic s1_start, s1_bit_valid, s1_a_bit, s1_b_bit;
  logic s1_bit_ready, s1_busy, s1_result_valid, s1_less, s1_equal, s1_greater;

  int checks;
  int failures;

  serial_lsb_first_comparator #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .bit_ready(bit_ready), .busy(busy),
    .result_valid(result_valid), .less(less), .equal(equal), .greater(greater)
  );

  serial_lsb_first_comparator #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .bit_valid(s1_bit_valid),
    .a_bit(s1_a_bit), .b_bit(s1_b_bit), .bit_ready(s1_bit_ready), .busy(s1_busy),
    .result_valid(s1_result_valid), .less(s1_less), .equal(s1_equal), .greater(s1_greater)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start (with a conflicting beat that must be ignored), then streams a/b LSB first.
  // A set bit in stall_mask inserts one idle cycle after that beat.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] stall_mask, input logic [2:0] exp_leg);
    start     = 1'b1;
    bit_valid = 1'b1;
    a_bit     = 1'b1;
    b_bit     = 1'b0;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    checkOutput({tag, "_after_start"}, {4'b0, busy, result_valid, less | equal, greater},
                8'b0000_1000);
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      a_bit     = a[i];
      b_bit     = b[i];
      if (i == 7)
        checkOutput({tag, "_pending"}, {6'b0, bit_ready, result_valid}, 8'b0000_0010);
      tick();
      if (stall_mask[i]) begin
        bit_valid = 1'b0;
        a_bit     = ~a_bit;
        b_bit     = ~b_bit;
        checkOutput({tag, "_stall_ready"}, {6'b0, bit_ready, result_valid}, 8'b0000_0010);
        tick();
      end
    end
    bit_valid = 1'b0;
    checkOutput({tag, "_result"}, {busy, bit_ready, 1'b0, result_valid, 1'b0, less, equal, greater},
                {4'b0001, 1'b0, exp_leg});
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    bit_valid    = 1'b0;
    a_bit        = 1'b0;
    b_bit        = 1'b0;
    s1_start     = 1'b0;
    s1_bit_valid = 1'b0;
    s1_a_bit     = 1'b0;
    s1_b_bit     = 1'b0;

    repeat (3) tick();
    checkOutput("reset_held", {2'b0, bit_ready, busy, result_valid, less, equal, greater}, 8'h00);
    rst_n     = 1'b1;
    bit_valid = 1'b1;
    a_bit     = 1'b1;
    repeat (2) tick();
    bit_valid = 1'b0;
    checkOutput("idle_no_start", {2'b0, bit_ready, busy, result_valid, less, equal, greater}, 8'h00);

    applyStimulus("eq_5a", 8'h5A, 8'h5A, 8'h00, 3'b010);
    applyStimulus("gt_80_7f", 8'h80, 8'h7F, 8'h00, 3'b001);

    bit_valid = 1'b1;
    a_bit     = 1'b0;
    b_bit     = 1'b1;
    repeat (3) tick();
    bit_valid = 1'b0;
    checkOutput("done_hold", {bit_ready, busy, 2'b0, result_valid, less, equal, greater}, 8'b0000_1001);

    applyStimulus("eq_33_b2b", 8'h33, 8'h33, 8'h00, 3'b010);
    applyStimulus("lt_01_02", 8'h01, 8'h02, 8'h00, 3'b100);
    applyStimulus("gt_ff_fe_stall", 8'hFF, 8'hFE, 8'b0001_0010, 3'b001);

    // Partial comparison strongly favouring A, then a restart
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      a_bit     = 1'b1;
      b_bit     = 1'b0;
      tick();
    end
    applyStimulus("lt_10_20_restart", 8'h10, 8'h20, 8'h00, 3'b100);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      a_bit     = 1'b0;
      b_bit     = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    checkOutput("midop_busy", {6'b0, busy, bit_ready}, 8'b0000_0011);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midop_async_reset", {2'b0, bit_ready, busy, result_valid, less, equal, greater}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bit_valid = 1'b1;
    repeat (5) tick();
    bit_valid = 1'b0;
    checkOutput("after_reset_idle", {2'b0, bit_ready, busy, result_valid, less, equal, greater}, 8'h00);

    s1_start = 1'b1;
    tick();
    s1_start     = 1'b0;
    s1_bit_valid = 1'b1;
    s1_a_bit     = 1'b0;
    s1_b_bit     = 1'b1;
    checkOutput("w1_shift", {3'b0, s1_bit_ready, s1_busy, s1_result_valid, s1_less, s1_greater}, 8'b0001_1000);
    tick();
    s1_bit_valid = 1'b0;
    checkOutput("w1_less", {2'b0, s1_bit_ready, s1_busy, s1_result_valid, s1_less, s1_equal, s1_greater},
                8'b0000_1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_lsb_first_comparator.md
Name: serial_lsb_first_comparator

Overview:
- Sequential magnitude comparator for two unsigned WIDTH-bit operands A and B.
- Operands arrive serially, one bit pair per accepted beat, LSB first. This is the opposite scan order to the MSB-first cascaded parallel comparator already in the design.
- Presents registered less/equal/greater flags with a result-valid indication.
- Used where operands stream out of shift registers or serial links, so no parallel capture is needed.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a new comparison; clears the running state.
- bit_valid  input  1  a_bit/b_bit hold a valid bit pair this cycle.
- a_bit  input  1  current bit of A; bit 0 arrives first.
- b_bit  input  1  current bit of B; bit 0 arrives first.
- bit_ready  output  1  block accepts a bit pair this cycle.
- busy  output  1  comparison in progress.
- result_valid  output  1  less/equal/greater hold a completed result.
- less  output  1  A < B.
- equal  output  1  A == B.
- greater  output  1  A > B.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, or after it deasserts, and before the first start:
  - state=IDLE, bit counter=0, running flags cleared.
  - bit_ready=0, busy=0, result_valid=0, less=0, equal=0, greater=0.
- Reset mid-comparison aborts it immediately. No partial result is ever presented.
- States:
  - IDLE: bit_ready=0, busy=0. start=1 -> SHIFT. The running flags are set to run_eq=1, run_lt=0, run_gt=0; counter=0; result_valid=0; less/equal/greater=0.
  - SHIFT: bit_ready=1, busy=1.
    - A beat is accepted when bit_valid=1 and bit_ready=1.
    - On an accepted beat, if a_bit != b_bit, the running flags are overwritten: lt = ~a_bit & b_bit, gt = a_bit & ~b_bit, eq=0. A later (more significant) differing bit dominates.
    - If a_bit == b_bit, the running flags are held unchanged.
    - The counter increments on each accepted beat.
    - bit_valid=0 cycles are stalls: no state change, no timeout.
    - The beat accepted with counter==WIDTH-1 -> DONE. On that same edge, less/equal/greater are loaded with the flags updated by this final bit, and result_valid is set to 1.
  - DONE: bit_ready=0, busy=0, result_valid=1. Outputs hold until the next start. start=1 -> SHIFT with the same clearing as from IDLE.
- Latency: result_valid and the flags are valid in the cycle after the edge that accepted the WIDTH-th beat. With no stalls, the minimum from the start cycle to result_valid is WIDTH+1 cycles.
- Exactly one of less/equal/greater is 1 whenever result_valid=1. All three are 0 whenever result_valid=0.
- start during SHIFT:
  - Abort and restart: counter=0, running flags re-initialised, state stays SHIFT.
  - Any bit_valid in that same cycle is ignored and not counted.
- start and bit_valid together in IDLE or DONE: start wins; the bit is ignored.
- Counter width is clog2(WIDTH)+1. It never wraps, because the state leaves SHIFT at WIDTH-1.
- WIDTH=1: a single accepted beat completes the comparison.
- The outputs are driven directly from registers. There is no combinational path from any input to less/equal/greater/result_valid.
- bit_ready and busy are decoded from the state register.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, release, no start -> all outputs 0, bit_ready=0.
- Equal operands: WIDTH=8, start, stream A=0x5A, B=0x5A LSB-first with no stalls -> result_valid=1 on cycle 9 after start, equal=1, less=0, greater=0.
- MSB dominance: A=0x80, B=0x7F -> greater=1. A=0x01, B=0x02 -> less=1, even though bit0 alone favours A.
- Stalls: A=0xFF, B=0xFE with bit_valid=0 inserted after beats 2 and 5 -> bit_ready stays 1 through the stalls; greater=1 only after the 8th accepted beat.
- Restart and reset mid-operation:
  - Start, send 4 beats, assert start again, then send a full A=0x10, B=0x20 stream -> less=1; the earlier beats have no effect.
  - Separately, pull rst_n low after 3 beats -> outputs go to 0 asynchronously and the state is IDLE.
- Back-to-back: from DONE with greater=1, assert start -> result_valid=0 and flags 0 the next cycle; stream 0x33 vs 0x33 -> equal=1.
- WIDTH=1 build: start, beat a=0, b=1 -> less=1 two cycles after start.
